voice_amp_scheduler: RTL and testbench
======================================

# voice_amp_scheduler

Time-multiplexed amplitude scaler that shares one registered signed multiplier among NUM_VOICES voices. On each sample tick it snapshots every voice's sample and envelope amplitude, scales each in turn, and publishes the scaled frame atomically. It sits between the per-voice tone/ADSR generators and the voice mixer, replacing NUM_VOICES separate amplitude multipliers.

## Interface

- DATA_BITS, 12, sample width (signed, two's complement)
- AMPLITUDE_BITS, 8, envelope amplitude width (unsigned)
- NUM_VOICES, 4, number of voices sharing the multiplier (≥2)

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle request to process a new frame
- din_bus  in  NUM_VOICES*DATA_BITS  voice v sample at [v*DATA_BITS +: DATA_BITS], signed
- amp_bus  in  NUM_VOICES*AMPLITUDE_BITS  voice v amplitude at [v*AMPLITUDE_BITS +: AMPLITUDE_BITS], unsigned
- dout_bus  out  NUM_VOICES*DATA_BITS  scaled frame, same packing as din_bus, signed
- dout_valid  out  1  one-cycle pulse: dout_bus just updated
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: a tick arrived while busy

## Operation

- States: IDLE, RUN, FLUSH, COMMIT.
- IDLE: on edge with sample_tick=1, copy din_bus/amp_bus into shadow registers, idx←0, go RUN. Inputs are not sampled again until the next accepted tick.
- RUN: each edge issues voice idx: prod←shadow_din[idx] × {1'b0, shadow_amp[idx]} (signed multiply), prod_idx←idx, prod_vld←1, idx←idx+1. Edge issuing idx=NUM_VOICES-1 goes FLUSH.
- Write-back (any state): on edge with prod_vld=1, staging[prod_idx]←prod[DATA_BITS+AMPLITUDE_BITS-1 -: DATA_BITS]; prod_vld clears when no issue occurs.
- FLUSH: one edge; last product written to staging; go COMMIT.
- COMMIT: one edge; dout_bus←staging (all voices simultaneously), dout_valid←1, go IDLE.
- Arithmetic: product is DATA_BITS+AMPLITUDE_BITS bits signed, never overflows; result = floor(din×amp / 2^AMPLITUDE_BITS). amp=0 gives 0; full-scale amp gives din×(2^A−1)/2^A, never exactly din.
- Overrun: sample_tick=1 on any edge where state ≠ IDLE (including the COMMIT edge) is ignored and sets overrun; overrun clears only on reset. The in-progress frame is unaffected.
- dout_bus holds the last committed frame between commits; partial frames are never visible.

## Timing

- Reset (rst_n low, asynchronous): state IDLE, dout_bus=0, dout_valid=0, busy=0, overrun=0, shadow/staging/prod/prod_vld/idx cleared. Reset mid-frame discards the frame; no dout_valid afterwards.
- Tick accepted at edge E0 → RUN issues at E1..E(N) (N=NUM_VOICES) → FLUSH at E(N+1) → COMMIT at E(N+2). dout_valid high for exactly the cycle following E(N+2); busy high from after E0 through E(N+2).
- Latency tick→dout_valid: N+2 clock edges. Minimum accepted tick spacing: N+3 cycles (a tick on the first cycle busy is low is accepted).
- dout_valid is never asserted for two consecutive cycles.

## Test plan

- Reset: hold rst_n low mid-RUN with nonzero dout_bus → all outputs 0 immediately; after release, no dout_valid until a new tick.
- Scaling, N=4: din={1024, −2048, 2047, −1}, amp={128, 255, 255, 1}, tick → after N+2 edges dout={512, −2040, 2039, −1}, dout_valid single pulse.
- Zero/unity edges: amp={0, 255, 0, 255}, din={2047, 256, −2048, 0} → dout={0, 255, 0, 0}.
- Snapshot: change din_bus/amp_bus every cycle after an accepted tick → dout reflects only tick-edge values; dout_bus unchanged until the commit edge.
- Overrun: tick at E0 and again at E3 and at the COMMIT edge → one frame only, overrun=1 from E3 onward and stays set; next tick at E(N+3) accepted normally.
- Back-to-back at max rate: ticks every N+3 cycles for 10 frames with varying data → 10 dout_valid pulses, each frame correct, overrun stays 0.

Source files
------------

// File: rtl/voice_amp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voice_amp_scheduler
// Description : Time-multiplexed amplitude scaler. A single registered signed
//               multiplier is shared by NUM_VOICES voices. Each sample tick
//               snapshots all voices, scales them one per cycle, and publishes
//               the scaled frame in one atomic update.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_amp_scheduler #(
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8,
  parameter int NUM_VOICES     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sample_tick,
  input  logic [NUM_VOICES*DATA_BITS-1:0]      din_bus,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] amp_bus,
  output logic [NUM_VOICES*DATA_BITS-1:0]      dout_bus,
  output logic                                 dout_valid,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int PROD_BITS = DATA_BITS + AMPLITUDE_BITS;
  localparam int IDX_BITS  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // FSM decode strobes
  logic accept;   // tick taken in IDLE: snapshot inputs
  logic issue;    // one voice enters the multiplier this cycle
  logic commit;   // staging becomes the visible frame

  // Frame snapshot taken on the accepted tick
  logic signed [DATA_BITS-1:0]      shadow_din [NUM_VOICES];
  logic        [AMPLITUDE_BITS-1:0] shadow_amp [NUM_VOICES];
  logic        [IDX_BITS-1:0]       idx;

  // Shared multiplier and its output register
  logic signed [DATA_BITS-1:0]      mul_a;
  logic signed [AMPLITUDE_BITS:0]   mul_b;
  logic signed [PROD_BITS-1:0]      mul_full;
  logic signed [PROD_BITS-1:0]      prod;
  logic        [IDX_BITS-1:0]       prod_idx;
  logic                             prod_vld;

  // Scaled results collect here until the whole frame is ready
  logic signed [DATA_BITS-1:0]      staging  [NUM_VOICES];
  logic signed [DATA_BITS-1:0]      dout_reg [NUM_VOICES];

  // The fractional product bits are discarded by the floor scaling
  logic unused_prod_frac;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_tick) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Snapshot every voice on the accepted tick; inputs are ignored otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        shadow_din[v] <= '0;
        shadow_amp[v] <= '0;
      end
    end else if (accept) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        shadow_din[v] <= din_bus[v*DATA_BITS +: DATA_BITS];
        shadow_amp[v] <= amp_bus[v*AMPLITUDE_BITS +: AMPLITUDE_BITS];
      end
    end
  end

  // Voice pointer: restarts at each accepted tick, advances per issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (issue) begin
      idx <= idx + 1'b1;
    end
  end

  // Amplitude is unsigned, so it is zero-extended before the signed multiply.
  // The true product always fits in PROD_BITS, so a PROD_BITS-wide multiply
  // of the sign-extended operands gives the exact result.
  assign mul_a    = shadow_din[idx];
  assign mul_b    = $signed({1'b0, shadow_amp[idx]});
  assign mul_full = PROD_BITS'(mul_a) * PROD_BITS'(mul_b);

  // Multiplier output register, tagged with the voice it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_idx <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= issue;
      if (issue) begin
        prod     <= mul_full;
        prod_idx <= idx;
      end
    end
  end

  // Write-back: the top DATA_BITS of the product are floor(din*amp / 2^A)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        staging[v] <= '0;
      end
    end else if (prod_vld) begin
      staging[prod_idx] <= prod[PROD_BITS-1 -: DATA_BITS];
    end
  end

  assign unused_prod_frac = ^prod[AMPLITUDE_BITS-1:0];

  // Publish the whole frame at once so partial results are never visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        dout_reg[v] <= '0;
      end
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= commit;
      if (commit) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          dout_reg[v] <= staging[v];
        end
      end
    end
  end

  // Sticky flag: a tick arriving while a frame is in flight is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (sample_tick && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
      assign dout_bus[v*DATA_BITS +: DATA_BITS] = dout_reg[v];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_voice_amp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_amp_scheduler
// Description : Scoreboard bench for voice_amp_scheduler. Stimulus pushes the
//               expected frame; a negedge monitor pops and compares whenever
//               dout_valid is seen, and checks that dout_bus holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_amp_scheduler;

  localparam int N  = 4;
  localparam int DB = 12;
  localparam int AB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sample_tick;
  logic [N*DB-1:0] din_bus;
  logic [N*AB-1:0] amp_bus;
  logic [N*DB-1:0] dout_bus;
  logic            dout_valid;
  logic            busy;
  logic            overrun;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  logic [N*DB-1:0] exp_q [$];
  logic [N*DB-1:0] last_frame = '0;
  logic            prev_valid = 1'b0;

  voice_amp_scheduler #(
    .DATA_BITS      (DB),
    .AMPLITUDE_BITS (AB),
    .NUM_VOICES     (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .din_bus     (din_bus),
    .amp_bus     (amp_bus),
    .dout_bus    (dout_bus),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d0, input int d1, input int d2, input int d3,
                        input int a0, input int a1, input int a2, input int a3);
    din_bus[0*DB +: DB] = d0[DB-1:0];
    din_bus[1*DB +: DB] = d1[DB-1:0];
    din_bus[2*DB +: DB] = d2[DB-1:0];
    din_bus[3*DB +: DB] = d3[DB-1:0];
    amp_bus[0*AB +: AB] = a0[AB-1:0];
    amp_bus[1*AB +: AB] = a1[AB-1:0];
    amp_bus[2*AB +: AB] = a2[AB-1:0];
    amp_bus[3*AB +: AB] = a3[AB-1:0];
  endtask

  task automatic push_exp(input int e0, input int e1, input int e2, input int e3);
    logic [N*DB-1:0] f;
    f[0*DB +: DB] = e0[DB-1:0];
    f[1*DB +: DB] = e1[DB-1:0];
    f[2*DB +: DB] = e2[DB-1:0];
    f[3*DB +: DB] = e3[DB-1:0];
    exp_q.push_back(f);
  endtask

  // Called just after a rising edge; the tick is taken on the next edge (E0)
  task automatic tick();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  // Monitor: compare published frames, enforce hold and single-cycle pulse
  always @(negedge clk) begin
    logic [N*DB-1:0] e;
    if (!rst_n) begin
      last_frame = '0;
      prev_valid = 1'b0;
    end else begin
      if (dout_valid) begin
        pulses++;
        check("valid_not_consecutive", {63'd0, prev_valid}, 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_dout_valid: got frame 0x%0h expected no pulse", dout_bus);
        end else begin
          e = exp_q.pop_front();
          for (int v = 0; v < N; v++) begin
            tests++;
            if (dout_bus[v*DB +: DB] !== e[v*DB +: DB]) begin
              fails++;
              $display("FAIL voice%0d_scaled: got %0d expected %0d", v,
                       $signed(dout_bus[v*DB +: DB]), $signed(e[v*DB +: DB]));
            end
          end
        end
        last_frame = dout_bus;
      end else begin
        check("dout_hold", {16'd0, dout_bus}, {16'd0, last_frame});
      end
      prev_valid = dout_valid;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ds [N];
    int as [N];
    int es [N];
    int p0;
    int wait_cyc;

    rst_n       = 1'b0;
    sample_tick = 1'b0;
    din_bus     = '0;
    amp_bus     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_bus",   {16'd0, dout_bus}, 64'd0);
    check("reset_dout_valid", {63'd0, dout_valid}, 64'd0);
    check("reset_busy",       {63'd0, busy}, 64'd0);
    check("reset_overrun",    {63'd0, overrun}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scaling with latency check: valid exactly N+2 edges after the tick edge
    set_in(1024, -2048, 2047, -1, 128, 255, 255, 1);
    push_exp(512, -2040, 2039, -1);
    tick();
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    repeat (N + 1) begin
      @(posedge clk); #1;
      check("no_early_valid", {63'd0, dout_valid}, 64'd0);
    end
    check("busy_in_commit", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("valid_at_latency", {63'd0, dout_valid}, 64'd1);
    check("idle_after_commit", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("valid_single_pulse", {63'd0, dout_valid}, 64'd0);

    // Zero and near-unity amplitudes
    set_in(2047, 256, -2048, 0, 0, 255, 0, 255);
    push_exp(0, 255, 0, 0);
    tick();
    repeat (N + 3) @(posedge clk);
    #1;

    // Snapshot: inputs scrambled every cycle after the accepted tick
    set_in(100, -300, 500, -700, 64, 200, 32, 255);
    push_exp(25, -235, 62, -698);
    tick();
    repeat (N + 3) begin
      din_bus = {$urandom, $urandom};
      amp_bus = $urandom;
      @(posedge clk); #1;
    end

    // Overrun: extra ticks at E3 and at the commit edge are dropped
    set_in(-1000, 999, 0, 2047, 10, 100, 255, 128);
    push_exp(-40, 390, 0, 1023);
    tick();                                   // now just after E0
    @(posedge clk); @(posedge clk); #1;       // just after E2
    check("overrun_before", {63'd0, overrun}, 64'd0);
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E3
    sample_tick = 1'b0;
    check("overrun_set_e3", {63'd0, overrun}, 64'd1);
    check("busy_e3", {63'd0, busy}, 64'd1);
    @(posedge clk); @(posedge clk); #1;       // just after E5
    sample_tick = 1'b1;
    @(posedge clk); #1;                       // E6 = commit edge
    sample_tick = 1'b0;
    check("commit_valid_with_tick", {63'd0, dout_valid}, 64'd1);
    check("idle_after_dropped_tick", {63'd0, busy}, 64'd0);
    set_in(300, -300, 1500, -1500, 255, 255, 170, 170);
    push_exp(298, -299, 996, -997);
    tick();                                   // E7 accepted
    check("accept_at_n_plus_3", {63'd0, busy}, 64'd1);
    repeat (N + 3) @(posedge clk);
    #1;
    check("overrun_sticky", {63'd0, overrun}, 64'd1);

    // Asynchronous reset in the middle of RUN discards the frame
    set_in(1000, 1000, 1000, 1000, 200, 200, 200, 200);
    tick();
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout_bus", {16'd0, dout_bus}, 64'd0);
    check("async_rst_valid",    {63'd0, dout_valid}, 64'd0);
    check("async_rst_busy",     {63'd0, busy}, 64'd0);
    check("async_rst_overrun",  {63'd0, overrun}, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_valid_after_reset", {63'd0, dout_valid}, 64'd0);

    // Back-to-back frames at the maximum accepted rate
    p0 = pulses;
    for (int f = 0; f < 10; f++) begin
      for (int v = 0; v < N; v++) begin
        ds[v] = int'($urandom_range(0, 4095)) - 2048;
        as[v] = int'($urandom_range(0, 255));
        es[v] = (ds[v] * as[v]) >>> AB;
      end
      if (f == 0) begin
        ds[0] = -2048; as[0] = 255; es[0] = -2040;
        ds[1] = 2047;  as[1] = 1;   es[1] = 7;
      end
      set_in(ds[0], ds[1], ds[2], ds[3], as[0], as[1], as[2], as[3]);
      push_exp(es[0], es[1], es[2], es[3]);
      tick();
      repeat (N + 2) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
    check("b2b_pulse_count", 64'(pulses - p0), 64'd10);
    check("b2b_overrun_clear", {63'd0, overrun}, 64'd0);

    // Drain the scoreboard within a bounded number of cycles
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 40) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("total_pulses", 64'(pulses), 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
